rv32i_core: RTL and testbench
=============================

RV32I_CORE -- requirements
Module: rv32i_core

Interface
REQ-001 The module SHALL have parameter RESET_VECTOR, default 32'h0000_0000, meaning the PC loaded on reset.
REQ-002 The module SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit, the reset: asynchronous and active-low.
REQ-004 The module SHALL have port imem_addr, output, 16 bits, instruction byte address, always word aligned (pc[15:0]).
REQ-005 The module SHALL have port imem_oe, output, 1 bit, instruction read request, a one-cycle pulse.
REQ-006 The module SHALL have port imem_rdata, input, 32 bits, instruction word, valid only while imem_ready=1.
REQ-007 The module SHALL have port imem_ready, input, 1 bit, instruction read response strobe.
REQ-008 The module SHALL have port mem_addr, output, 32 bits, data word address {ea[31:2],2'b00}.
REQ-009 The module SHALL have port mem_oe, output, 1 bit, data access request, a one-cycle pulse.
REQ-010 The module SHALL have port mem_wdata, output, 32 bits, store data shifted into its byte lanes.
REQ-011 The module SHALL have port mem_we, output, 4 bits, byte-lane write enables; 0 means read.
REQ-012 The module SHALL have port mem_rdata, input, 32 bits, load data, valid only while mem_ready=1.
REQ-013 The module SHALL have port mem_ready, input, 1 bit, load response strobe.

Function
REQ-014 The core SHALL implement RV32I: LUI, AUIPC, JAL, JALR, branches, loads, stores, OP-IMM, OP, FENCE/FENCE.I (as no-op), ECALL, MRET, CSRRW/S/C and CSRRWI/SI/CI.
REQ-015 The core SHALL sequence FSM states FETCH -> IWAIT -> EXEC, then MWAIT for loads, then FETCH.
- FETCH: imem_oe=1 and imem_addr=pc for exactly one cycle.
- IWAIT: hold until imem_ready=1, then latch imem_rdata; ready is ignored in every other state.
REQ-016 In EXEC the core SHALL read operands, compute the result, write rd and update pc in one cycle.
- Non-memory instructions and stores: 3 cycles minimum.
- Stores: issue mem_oe with nonzero mem_we and do not wait for any response.
REQ-017 Loads SHALL issue mem_oe with mem_we=0 in EXEC, wait in MWAIT for mem_ready (any latency), then extract, extend and write rd; minimum 4 cycles.
REQ-018 Byte/half lane selection SHALL use ea[1:0] for byte accesses and ea[1] for halfword accesses; word accesses ignore ea[1:0].
- SB/SH: replicate data into lanes, e.g. SB at ea=0x102 gives we=4'b0100.
- Misaligned halves/words are not trapped.
REQ-019 Writes to x0 SHALL be discarded; reads of x0 SHALL return 0.
REQ-020 Shifts SHALL use rs2/imm[4:0]; SLT/SLTI signed, SLTU/SLTIU unsigned; SRA/SRAI arithmetic.
REQ-021 JALR target SHALL be (rs1+imm) with bit0 cleared; JAL/JALR write pc+4 to rd.
REQ-022 CSRs SHALL be mtvec 0x305, mepc 0x341, mcause 0x342 (all R/W), and mcycle 0xB00 / cycle 0xC00 (read-only, free-running count since reset).
- Other CSR addresses read 0; writes to them are ignored.
- CSR set/clear with zero operand does not write.
REQ-023 ECALL SHALL set mepc=pc, mcause=11 and jump to {mtvec[31:2],2'b00}; MRET SHALL jump to mepc.
REQ-024 Unknown opcodes SHALL execute as no-ops: pc+4, no register write.
REQ-025 Outputs other than the strobes SHALL hold their last values when idle; mem_oe and imem_oe are never asserted in the same cycle.

Reset
REQ-026 While rst=0, the core SHALL force imem_oe=0, mem_oe=0, mem_we=0, mem_addr=0, mem_wdata=0, imem_addr=RESET_VECTOR[15:0], pc=RESET_VECTOR, all GPRs=0, all CSRs=0, and state=FETCH.
REQ-027 Reset asserted mid-instruction SHALL abandon the instruction, with no GPR/CSR update; a response arriving during or after reset while in FETCH SHALL be ignored.
REQ-028 The first imem_oe pulse SHALL occur on the first rising edge after rst deasserts.

Structure
REQ-029 A shared package SHALL hold the opcode, funct3/funct7 and CSR-address constants plus the FSM state enum.
REQ-030 The register file SHALL be the one sub-module, rv32i_regfile: 2 async read ports, 1 write port, x0 hardwired to zero.

Verification
REQ-031 Release reset with RESET_VECTOR=0 -> imem_oe pulses with imem_addr=0x0000; mem_oe stays 0 during reset.
REQ-032 Run addi x10,x0,5; lui x5,0xF0000; sw x10,0(x5) -> mem_oe=1, mem_addr=0xF0000000, mem_we=4'b1111, mem_wdata=0x00000005.
REQ-033 lb x7,6(x0) with mem_rdata=0x00800000 returned after a 3-cycle delay -> x7=0xFFFFFF80; lbu gives 0x00000080.
REQ-034 sb of x6=0x41 to 0x102 -> mem_addr=0x100, mem_we=4'b0100, mem_wdata=0x41414141.
REQ-035 beq x0,x0,+16 at pc 0x20 -> next imem_addr=0x30; addi x0,x0,1 leaves x0 at 0.
REQ-036 csrw mtvec with 0x100, then ecall at 0x40 -> imem_addr=0x100 and mcause=11; mret -> imem_addr=0x40.

Source files
------------

// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared RV32I opcode, funct and CSR constants plus the core FSM state enum
package rv32i_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam logic [6:0] F7_ALT = 7'b0100000;

  localparam logic [11:0] SYS_ECALL   = 12'h000;
  localparam logic [11:0] SYS_MRET    = 12'h302;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MCYCLE  = 12'hB00;
  localparam logic [11:0] CSR_CYCLE   = 12'hC00;

  typedef enum logic [1:0] {S_FETCH, S_IWAIT, S_EXEC, S_MWAIT} state_t;

endpackage

// File: rtl/rv32i_regfile.sv
// rtl/rv32i_regfile.sv - 32x32 register file, two async read ports, one write port, x0 fixed at zero
module rv32i_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  i_ra1,
  input  logic [4:0]  i_ra2,
  output logic [31:0] o_rd1,
  output logic [31:0] o_rd2,
  input  logic        i_we,
  input  logic [4:0]  i_wa,
  input  logic [31:0] i_wd
);

  logic [31:0] r_regs [0:31];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (i_we && i_wa != 5'd0) begin
      r_regs[i_wa] <= i_wd;
    end
  end

  assign o_rd1 = (i_ra1 == 5'd0) ? 32'd0 : r_regs[i_ra1];
  assign o_rd2 = (i_ra2 == 5'd0) ? 32'd0 : r_regs[i_ra2];

endmodule

// File: rtl/rv32i_core.sv
// rtl/rv32i_core.sv - multi-cycle RV32I core: FETCH, IWAIT, EXEC and MWAIT for loads
module rv32i_core
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] imem_addr,
  output logic        imem_oe,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] mem_addr,
  output logic        mem_oe,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_we,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  state_t      r_state;
  logic [31:0] r_pc, r_ir, r_mtvec, r_mepc, r_mcause, r_cycle;
  logic [1:0]  r_ea_lo;
  logic        r_imem_oe, r_mem_oe;
  logic [15:0] r_imem_addr;
  logic [31:0] r_mem_addr, r_mem_wdata;
  logic [3:0]  r_mem_we;

  logic [6:0]  w_op;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic [2:0]  w_f3;
  logic        w_alt;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [31:0] w_rv1, w_rv2, w_alu_b, w_alu, w_ea, w_pc4;
  logic        w_take;
  logic [31:0] w_st_data, w_lword, w_ld;
  logic [3:0]  w_st_we;
  logic [4:0]  w_lsh;
  logic [11:0] w_csr_addr;
  logic [31:0] w_csr_old, w_csr_src, w_csr_new;
  logic        w_is_csr, w_csr_we, w_is_ecall;
  logic [31:0] w_next_pc, w_rd_val, w_rf_wd;
  logic        w_rd_we, w_rf_we;

  assign w_op    = r_ir[6:0];
  assign w_rd    = r_ir[11:7];
  assign w_f3    = r_ir[14:12];
  assign w_rs1   = r_ir[19:15];
  assign w_rs2   = r_ir[24:20];
  assign w_alt   = (r_ir[31:25] == F7_ALT);
  assign w_imm_i = {{20{r_ir[31]}}, r_ir[31:20]};
  assign w_imm_s = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
  assign w_imm_b = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
  assign w_imm_u = {r_ir[31:12], 12'b0};
  assign w_imm_j = {{11{r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};
  assign w_pc4   = r_pc + 32'd4;

  rv32i_regfile u_regfile (
    .clk(clk), .rst(rst), .i_ra1(w_rs1), .i_ra2(w_rs2), .o_rd1(w_rv1), .o_rd2(w_rv2),
    .i_we(w_rf_we), .i_wa(w_rd), .i_wd(w_rf_wd)
  );

  assign w_alu_b = (w_op == OP_OP) ? w_rv2 : w_imm_i;

  always_comb begin
    w_alu = '0;
    case (w_f3)
      F3_ADD:  w_alu = (w_op == OP_OP && w_alt) ? w_rv1 - w_alu_b : w_rv1 + w_alu_b;
      F3_SLL:  w_alu = w_rv1 << w_alu_b[4:0];
      F3_SLT:  w_alu = {31'b0, $signed(w_rv1) < $signed(w_alu_b)};
      F3_SLTU: w_alu = {31'b0, w_rv1 < w_alu_b};
      F3_XOR:  w_alu = w_rv1 ^ w_alu_b;
      F3_SR:   w_alu = w_alt ? $unsigned($signed(w_rv1) >>> w_alu_b[4:0]) : w_rv1 >> w_alu_b[4:0];
      F3_OR:   w_alu = w_rv1 | w_alu_b;
      F3_AND:  w_alu = w_rv1 & w_alu_b;
      default: w_alu = '0;
    endcase
  end

  always_comb begin
    w_take = 1'b0;
    case (w_f3)
      F3_BEQ:  w_take = (w_rv1 == w_rv2);
      F3_BNE:  w_take = (w_rv1 != w_rv2);
      F3_BLT:  w_take = ($signed(w_rv1) < $signed(w_rv2));
      F3_BGE:  w_take = ($signed(w_rv1) >= $signed(w_rv2));
      F3_BLTU: w_take = (w_rv1 < w_rv2);
      F3_BGEU: w_take = (w_rv1 >= w_rv2);
      default: w_take = 1'b0;
    endcase
  end

  // Narrow stores replicate data across all lanes; the enables pick the live lane.
  assign w_ea = w_rv1 + ((w_op == OP_STORE) ? w_imm_s : w_imm_i);

  always_comb begin
    w_st_data = w_rv2;
    w_st_we   = 4'b1111;
    if (w_f3 == F3_B) begin
      w_st_data = {4{w_rv2[7:0]}};
      w_st_we   = 4'b0001 << w_ea[1:0];
    end else if (w_f3 == F3_H) begin
      w_st_data = {2{w_rv2[15:0]}};
      w_st_we   = w_ea[1] ? 4'b1100 : 4'b0011;
    end
  end

  always_comb begin
    w_lsh = '0;
    if (w_f3 == F3_B || w_f3 == F3_BU)      w_lsh = {r_ea_lo, 3'b000};
    else if (w_f3 == F3_H || w_f3 == F3_HU) w_lsh = {r_ea_lo[1], 4'b0000};
    w_lword = mem_rdata >> w_lsh;
    case (w_f3)
      F3_B:    w_ld = {{24{w_lword[7]}}, w_lword[7:0]};
      F3_H:    w_ld = {{16{w_lword[15]}}, w_lword[15:0]};
      F3_BU:   w_ld = {24'b0, w_lword[7:0]};
      F3_HU:   w_ld = {16'b0, w_lword[15:0]};
      F3_W:    w_ld = w_lword;
      default: w_ld = w_lword;
    endcase
  end

  assign w_csr_addr = r_ir[31:20];
  assign w_csr_src  = w_f3[2] ? {27'b0, w_rs1} : w_rv1;
  assign w_is_csr   = (w_op == OP_SYSTEM) && (w_f3[1:0] != 2'b00);
  assign w_csr_we   = w_is_csr && (w_f3[1:0] == 2'b01 || w_csr_src != 32'd0);
  assign w_is_ecall = (w_op == OP_SYSTEM) && (w_f3 == 3'd0) && (w_csr_addr == SYS_ECALL);

  always_comb begin
    case (w_csr_addr)
      CSR_MTVEC:            w_csr_old = r_mtvec;
      CSR_MEPC:             w_csr_old = r_mepc;
      CSR_MCAUSE:           w_csr_old = r_mcause;
      CSR_MCYCLE, CSR_CYCLE: w_csr_old = r_cycle;
      default:              w_csr_old = '0;
    endcase
    case (w_f3[1:0])
      2'b01:   w_csr_new = w_csr_src;
      2'b10:   w_csr_new = w_csr_old | w_csr_src;
      default: w_csr_new = w_csr_old & ~w_csr_src;
    endcase
  end

  always_comb begin
    w_next_pc = w_pc4;
    w_rd_we   = 1'b0;
    w_rd_val  = w_alu;
    case (w_op)
      OP_LUI:    begin w_rd_we = 1'b1; w_rd_val = w_imm_u; end
      OP_AUIPC:  begin w_rd_we = 1'b1; w_rd_val = r_pc + w_imm_u; end
      OP_JAL:    begin w_rd_we = 1'b1; w_rd_val = w_pc4; w_next_pc = r_pc + w_imm_j; end
      OP_JALR:   begin w_rd_we = 1'b1; w_rd_val = w_pc4; w_next_pc = (w_rv1 + w_imm_i) & ~32'd1; end
      OP_BRANCH: if (w_take) w_next_pc = r_pc + w_imm_b;
      OP_IMM, OP_OP: w_rd_we = 1'b1;
      OP_SYSTEM: begin
        if (w_is_csr) begin
          w_rd_we  = 1'b1;
          w_rd_val = w_csr_old;
        end else if (w_is_ecall) begin
          w_next_pc = {r_mtvec[31:2], 2'b00};
        end else if (w_f3 == 3'd0 && w_csr_addr == SYS_MRET) begin
          w_next_pc = r_mepc;
        end
      end
      default: w_rd_we = 1'b0;
    endcase
  end

  assign w_rf_we = (r_state == S_EXEC && w_rd_we) || (r_state == S_MWAIT && mem_ready);
  assign w_rf_wd = (r_state == S_MWAIT) ? w_ld : w_rd_val;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_FETCH;
      r_pc        <= RESET_VECTOR;
      r_ir        <= '0;
      r_ea_lo     <= '0;
      r_mtvec     <= '0;
      r_mepc      <= '0;
      r_mcause    <= '0;
      r_cycle     <= '0;
      r_imem_oe   <= 1'b0;
      r_imem_addr <= RESET_VECTOR[15:0];
      r_mem_oe    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= '0;
    end else begin
      r_cycle   <= r_cycle + 32'd1;
      r_imem_oe <= 1'b0;
      r_mem_oe  <= 1'b0;
      case (r_state)
        S_FETCH: begin
          r_imem_oe   <= 1'b1;
          r_imem_addr <= r_pc[15:0];
          r_state     <= S_IWAIT;
        end
        S_IWAIT: if (imem_ready) begin
          r_ir    <= imem_rdata;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_pc    <= w_next_pc;
          r_state <= S_FETCH;
          if (w_op == OP_LOAD) begin
            r_mem_oe   <= 1'b1;
            r_mem_we   <= 4'b0000;
            r_mem_addr <= {w_ea[31:2], 2'b00};
            r_ea_lo    <= w_ea[1:0];
            r_state    <= S_MWAIT;
          end
          if (w_op == OP_STORE) begin
            r_mem_oe    <= 1'b1;
            r_mem_we    <= w_st_we;
            r_mem_addr  <= {w_ea[31:2], 2'b00};
            r_mem_wdata <= w_st_data;
          end
          if (w_is_ecall) begin
            r_mepc   <= r_pc;
            r_mcause <= 32'd11;
          end
          if (w_csr_we) begin
            case (w_csr_addr)
              CSR_MTVEC:  r_mtvec  <= w_csr_new;
              CSR_MEPC:   r_mepc   <= w_csr_new;
              CSR_MCAUSE: r_mcause <= w_csr_new;
              default:    r_mtvec  <= r_mtvec;
            endcase
          end
        end
        S_MWAIT: if (mem_ready) r_state <= S_FETCH;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  assign imem_oe   = r_imem_oe;
  assign imem_addr = r_imem_addr;
  assign mem_oe    = r_mem_oe;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_we    = r_mem_we;

endmodule

// File: tb/tb_rv32i_core.sv
// tb/tb_rv32i_core.sv - directed program with fetch/store/load scoreboards for rv32i_core
module tb_rv32i_core;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] imem_addr;
  logic        imem_oe;
  logic [31:0] imem_rdata = '0;
  logic        imem_ready = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_oe;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_we;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] data;
  } st_t;

  logic [15:0] fq [$];
  st_t         sq [$];
  logic [31:0] lq [$];
  logic [31:0] prog [0:127];
  logic [15:0] paddr = '0;
  int          idly = 0;
  int          ddly = 0;

  always #5 clk = ~clk;

  rv32i_core #(.RESET_VECTOR(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_oe(imem_oe), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .mem_addr(mem_addr), .mem_oe(mem_oe), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  function automatic logic [31:0] e_i(input int imm, input int rs1, input int f3, input int rd, input int op);
    logic [31:0] v, a, f, d, o;
    v = imm; a = rs1; f = f3; d = rd; o = op;
    return {v[11:0], a[4:0], f[2:0], d[4:0], o[6:0]};
  endfunction

  function automatic logic [31:0] e_s(input int imm, input int rs2, input int rs1, input int f3);
    logic [31:0] v, b, a, f;
    v = imm; b = rs2; a = rs1; f = f3;
    return {v[11:5], b[4:0], a[4:0], f[2:0], v[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] e_b(input int imm, input int rs2, input int rs1, input int f3);
    logic [31:0] v, b, a, f;
    v = imm; b = rs2; a = rs1; f = f3;
    return {v[12], v[10:5], b[4:0], a[4:0], f[2:0], v[4:1], v[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] e_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
    logic [31:0] s, b, a, f, d;
    s = f7; b = rs2; a = rs1; f = f3; d = rd;
    return {s[6:0], b[4:0], a[4:0], f[2:0], d[4:0], 7'b0110011};
  endfunction

  function automatic logic [31:0] e_j(input int imm, input int rd);
    logic [31:0] v, d;
    v = imm; d = rd;
    return {v[20], v[10:1], v[11], v[19:12], d[4:0], 7'b1101111};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic exp_st(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
    sq.push_back({a, w, d});
  endtask

  // Instruction memory: answer each fetch after 0..2 extra cycles.
  always @(negedge clk) begin
    if (imem_ready) imem_ready = 1'b0;
    if (idly > 0) begin
      idly--;
      if (idly == 0) begin imem_ready = 1'b1; imem_rdata = prog[paddr[8:2]]; end
    end
    if (imem_oe) begin
      paddr = imem_addr;
      idly = $urandom_range(0, 2);
      if (idly == 0) begin imem_ready = 1'b1; imem_rdata = prog[paddr[8:2]]; end
    end
  end

  // Data memory: every load returns the same word after three cycles.
  always @(negedge clk) begin
    if (mem_ready) mem_ready = 1'b0;
    if (ddly > 0) begin
      ddly--;
      if (ddly == 0) begin mem_ready = 1'b1; mem_rdata = 32'h0080_0000; end
    end
    if (mem_oe && mem_we == 4'b0000) ddly = 3;
  end

  always @(negedge clk) begin
    st_t s;
    if (imem_oe) begin
      chk("strobe_overlap", {31'b0, mem_oe}, 32'd0);
      if (fq.size() == 0) begin
        total++; bad++;
        $error("FAIL fetch_extra observed=%h expected=none", imem_addr);
      end else begin
        chk("fetch_addr", {16'b0, imem_addr}, {16'b0, fq.pop_front()});
      end
    end
    if (mem_oe && mem_we != 4'b0000) begin
      if (sq.size() == 0) begin
        total++; bad++;
        $error("FAIL store_extra observed=%h expected=none", mem_addr);
      end else begin
        s = sq.pop_front();
        chk("store_addr", mem_addr, s.addr);
        chk("store_we", {28'b0, mem_we}, {28'b0, s.we});
        chk("store_data", mem_wdata, s.data);
      end
    end else if (mem_oe) begin
      if (lq.size() == 0) begin
        total++; bad++;
        $error("FAIL load_extra observed=%h expected=none", mem_addr);
      end else begin
        chk("load_addr", mem_addr, lq.pop_front());
      end
    end
  end

  initial begin
    for (int i = 0; i < 128; i++) prog[i] = 32'h0;
    prog['h00 >> 2] = e_i(5, 0, 0, 10, 'h13);
    prog['h04 >> 2] = {20'hF0000, 5'd5, 7'b0110111};
    prog['h08 >> 2] = e_s(0, 10, 5, 2);
    prog['h0C >> 2] = e_i(6, 0, 0, 7, 'h03);
    prog['h10 >> 2] = e_s(0, 7, 0, 2);
    prog['h14 >> 2] = e_i(6, 0, 4, 7, 'h03);
    prog['h18 >> 2] = e_s(4, 7, 0, 2);
    prog['h1C >> 2] = e_i('h41, 0, 0, 6, 'h13);
    prog['h20 >> 2] = e_b(16, 0, 0, 0);
    prog['h24 >> 2] = e_i(99, 0, 0, 10, 'h13);
    prog['h28 >> 2] = e_i(99, 0, 0, 10, 'h13);
    prog['h2C >> 2] = e_i(99, 0, 0, 10, 'h13);
    prog['h30 >> 2] = e_s('h102, 6, 0, 0);
    prog['h34 >> 2] = e_i('h100, 0, 0, 9, 'h13);
    prog['h38 >> 2] = e_i('h305, 9, 1, 0, 'h73);
    prog['h3C >> 2] = e_i(1, 0, 0, 0, 'h13);
    prog['h40 >> 2] = 32'h0000_0073;
    prog['h100 >> 2] = e_i('h342, 0, 2, 8, 'h73);
    prog['h104 >> 2] = e_s(12, 8, 0, 2);
    prog['h108 >> 2] = e_s(16, 0, 0, 2);
    prog['h10C >> 2] = e_i('h341, 0, 2, 11, 'h73);
    prog['h110 >> 2] = e_s(20, 11, 0, 2);
    prog['h114 >> 2] = e_i(-16, 0, 0, 12, 'h13);
    prog['h118 >> 2] = e_i('h402, 12, 5, 13, 'h13);
    prog['h11C >> 2] = e_r(0, 12, 0, 3, 14);
    prog['h120 >> 2] = e_r('h20, 12, 0, 0, 15);
    prog['h124 >> 2] = e_s('h22, 13, 0, 1);
    prog['h128 >> 2] = e_r(0, 15, 14, 0, 16);
    prog['h12C >> 2] = e_s(24, 16, 0, 2);
    prog['h130 >> 2] = e_j(8, 1);
    prog['h134 >> 2] = e_i(99, 0, 0, 10, 'h13);
    prog['h138 >> 2] = e_s(28, 1, 0, 2);
    prog['h13C >> 2] = 32'h3020_0073;

    for (int a = 'h00; a <= 'h20; a += 4) fq.push_back(a[15:0]);
    for (int a = 'h30; a <= 'h40; a += 4) fq.push_back(a[15:0]);
    for (int a = 'h100; a <= 'h130; a += 4) fq.push_back(a[15:0]);
    fq.push_back(16'h0138);
    fq.push_back(16'h013C);
    fq.push_back(16'h0040);

    exp_st(32'hF000_0000, 4'b1111, 32'h0000_0005);
    exp_st(32'h0000_0000, 4'b1111, 32'hFFFF_FF80);
    exp_st(32'h0000_0004, 4'b1111, 32'h0000_0080);
    exp_st(32'h0000_0100, 4'b0100, 32'h4141_4141);
    exp_st(32'h0000_000C, 4'b1111, 32'h0000_000B);
    exp_st(32'h0000_0010, 4'b1111, 32'h0000_0000);
    exp_st(32'h0000_0014, 4'b1111, 32'h0000_0040);
    exp_st(32'h0000_0020, 4'b1100, 32'hFFFC_FFFC);
    exp_st(32'h0000_0018, 4'b1111, 32'h0000_0011);
    exp_st(32'h0000_001C, 4'b1111, 32'h0000_0134);
    lq.push_back(32'h0000_0004);
    lq.push_back(32'h0000_0004);

    repeat (3) @(negedge clk);
    chk("rst_imem_oe", {31'b0, imem_oe}, 32'd0);
    chk("rst_mem_oe", {31'b0, mem_oe}, 32'd0);
    chk("rst_imem_addr", {16'b0, imem_addr}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_we", {28'b0, mem_we}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("first_fetch_oe", {31'b0, imem_oe}, 32'd1);

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (fq.size() == 0 && sq.size() == 0 && lq.size() == 0) break;
    end
    chk("program_done", fq.size() + sq.size() + lq.size(), 32'd0);

    rst = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_imem_oe", {31'b0, imem_oe}, 32'd0);
    chk("mid_rst_mem_oe", {31'b0, mem_oe}, 32'd0);
    chk("mid_rst_imem_addr", {16'b0, imem_addr}, 32'd0);
    chk("mid_rst_mem_addr", mem_addr, 32'd0);
    chk("mid_rst_mem_we", {28'b0, mem_we}, 32'd0);
    chk("mid_rst_mem_wdata", mem_wdata, 32'd0);
    repeat (2) @(negedge clk);
    fq.push_back(16'h0000);
    rst = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (fq.size() == 0) break;
    end
    chk("refetch_done", fq.size(), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
